// File: rtl/sdram_wbuf.sv
// Posted-write FIFO and read sequencer in front of SDRAM channel 2 (req/ready-pulse handshake).
// Define SDRAM_WBUF_FORWARD_EN to let full-word reads complete from buffered writes.

module sdram_wbuf #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_din,
    input  logic [3:0]        cpu_be,
    input  logic              cpu_wr,
    output logic              cpu_wack,
    input  logic              cpu_rd,
    output logic [31:0]       cpu_dout,
    output logic              cpu_rdone,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_be,
    output logic              mem_rnw,
    output logic              mem_req,
    input  logic [31:0]       mem_dout,
    input  logic              mem_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [2:0] {IDLE, WREQ, WWAIT, RREQ, RWAIT} state_t;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic [3:0]        be_mem   [DEPTH];

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              mem_rnw_q, mem_rnw_d;
    logic              mem_req_q, mem_req_d;
    logic              rdone_q, rdone_d;
    logic [31:0]       dout_q, dout_d;
    logic              ready_d_q;

    logic              full_w, fifo_empty, push, ready_rise;
    logic [AW-1:0]     rd_idx;
    logic [ADDR_W-1:0] cpu_word_addr;

    assign full_w        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
    assign cpu_wack      = cpu_wr & ~full_w & ~reset;
    assign push          = cpu_wack;
    assign ready_rise    = mem_ready & ~ready_d_q;
    assign rd_idx        = rd_ptr_q[AW-1:0];
    assign cpu_word_addr = cpu_addr & WORD_MASK;

`ifdef SDRAM_WBUF_FORWARD_EN
    logic [PW-1:0] fill;
    logic [AW-1:0] idx;
    logic          any_match, partial_match, fwd_hit;
    logic [31:0]   fwd_data;

    assign fill = wr_ptr_q - rd_ptr_q;

    // Scan oldest to newest so the last match wins; any partial-BE match disables forwarding.
    always_comb begin
        any_match     = 1'b0;
        partial_match = 1'b0;
        fwd_data      = '0;
        idx           = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_idx + AW'(i);
            if ((PW'(i) < fill) && (addr_mem[idx] == cpu_word_addr)) begin
                any_match = 1'b1;
                fwd_data  = data_mem[idx];
                if (be_mem[idx] != 4'hF) partial_match = 1'b1;
            end
        end
    end

    assign fwd_hit = any_match & ~partial_match;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q[AW-1:0]] <= cpu_word_addr;
            data_mem[wr_ptr_q[AW-1:0]] <= cpu_din;
            be_mem[wr_ptr_q[AW-1:0]]   <= cpu_be;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_be_d    = mem_be_q;
        mem_rnw_d   = mem_rnw_q;
        mem_req_d   = 1'b0;
        rdone_d     = 1'b0;
        dout_d      = dout_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);

        if (cpu_rd && !pend_q) begin
`ifdef SDRAM_WBUF_FORWARD_EN
            if (fwd_hit) begin
                dout_d  = fwd_data;
                rdone_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = cpu_word_addr;
            end
`else
            pend_d      = 1'b1;
            pend_addr_d = cpu_word_addr;
`endif
        end

        // Writes drain before any pending read so reads observe all prior writes.
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    mem_addr_d = addr_mem[rd_idx];
                    mem_din_d  = data_mem[rd_idx];
                    mem_be_d   = be_mem[rd_idx];
                    mem_rnw_d  = 1'b0;
                    mem_req_d  = 1'b1;
                    state_d    = WREQ;
                end else if (pend_q) begin
                    mem_addr_d = pend_addr_q;
                    mem_be_d   = 4'hF;
                    mem_rnw_d  = 1'b1;
                    mem_req_d  = 1'b1;
                    state_d    = RREQ;
                end
            end
            WREQ:  state_d = WWAIT;
            RREQ:  state_d = RWAIT;
            WWAIT: begin
                if (ready_rise) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = IDLE;
                end
            end
            RWAIT: begin
                if (ready_rise) begin
                    dout_d  = mem_dout;
                    rdone_d = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_be_q    <= '0;
            mem_rnw_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            rdone_q     <= 1'b0;
            dout_q      <= '0;
            ready_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_be_q    <= mem_be_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_req_q   <= mem_req_d;
            rdone_q     <= rdone_d;
            dout_q      <= dout_d;
            ready_d_q   <= mem_ready;
        end
    end

    assign cpu_dout  = dout_q;
    assign cpu_rdone = rdone_q;
    assign full      = full_w;
    assign empty     = fifo_empty;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_be    = mem_be_q;
    assign mem_rnw   = mem_rnw_q;
    assign mem_req   = mem_req_q;

endmodule
